// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle from the pixel-timing master to renderers and the monitor.
interface vga_timing_gen_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic       frame_end;
  logic [7:0] frame_cnt;
  modport master (output x, y, hsync, vsync, video_on, p_tick, frame_end, frame_cnt);
  modport slave (input x, y, hsync, vsync, video_on, p_tick, frame_end, frame_cnt);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counters with registered sync/blank decode.
// Define VGA_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4
) (
  input logic clk,
  input logic rst_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_LO = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_END = 10'(H_VIS);
  localparam logic [9:0] V_END = 10'(V_VIS);
  logic [DW-1:0] div;
  logic [9:0] x, y, x_n, y_n;
  logic hsync, vsync, video_on, p_tick, x_wrap, frame_end;
  always_comb begin
    p_tick    = div == DIV_MAX;
    x_wrap    = p_tick && x == H_MAX;
    frame_end = x_wrap && y == V_MAX;
    x_n       = p_tick ? (x_wrap ? '0 : x + 10'd1) : x;
    y_n       = x_wrap ? (y == V_MAX ? '0 : y + 10'd1) : y;
  end
  // Decode from next-state counters so the registered flags line up with x/y.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div      <= '0;
      x        <= '0;
      y        <= '0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b1;
    end else begin
      div      <= p_tick ? '0 : div + DW'(1);
      x        <= x_n;
      y        <= y_n;
      hsync    <= !(x_n >= HS_LO && x_n <= HS_HI);
      vsync    <= !(y_n >= VS_LO && y_n <= VS_HI);
      video_on <= x_n < H_END && y_n < V_END;
    end
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  assign vga.frame_cnt = frame_cnt;
`else
  assign vga.frame_cnt = '0;
`endif
  assign vga.x         = x;
  assign vga.y         = y;
  assign vga.hsync     = hsync;
  assign vga.vsync     = vsync;
  assign vga.video_on  = video_on;
  assign vga.p_tick    = p_tick;
  assign vga.frame_end = frame_end;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a reduced raster checking every output against an edge-count model.
module tb_vga_timing_gen;
  localparam int H_VIS = 4, H_FP = 1, H_SYNC = 2, H_BP = 1;
  localparam int V_VIS = 3, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int CD = 3;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       pt;
    logic       fe;
    logic [7:0] fc;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n = 0;
  bit done = 1'b0;
  int total = 0;
  int bad = 0;
  obs_t q[$];
  vga_timing_gen_if vif();
  vga_timing_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vga(vif)
  );
  always #5 clk = ~clk;
  function automatic obs_t model(input int e);
    obs_t r;
    int p, px, py;
    if (e < 0) return '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b1, pt: 1'b0, fe: 1'b0, fc: 8'd0};
    p  = e / CD;
    px = p % HT;
    py = (p / HT) % VT;
    r.x  = 10'(px);
    r.y  = 10'(py);
    r.pt = (e % CD) == CD - 1;
    r.fe = r.pt && px == HT - 1 && py == VT - 1;
    r.hs = !(px >= H_VIS + H_FP && px < H_VIS + H_FP + H_SYNC);
    r.vs = !(py >= V_VIS + V_FP && py < V_VIS + V_FP + V_SYNC);
    r.vo = px < H_VIS && py < V_VIS;
    r.fc = FC_EN ? 8'((p / (HT * VT)) % 256) : 8'd0;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    if (rst_n) n++;
    q.push_back(model(rst_n ? n : -1));
  endtask
  task automatic assert_rst();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    n = 0;
    q.push_back(model(-1));
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1;
    q.push_back(model(-1));
    #2;
    rst_n = 1'b1;
  endtask
  initial begin
    repeat (3) step();
    total++;
    if (vif.x !== 10'd0 || vif.y !== 10'd0 || vif.hsync !== 1'b1 || vif.vsync !== 1'b1 ||
        vif.video_on !== 1'b1 || vif.p_tick !== 1'b0 || vif.frame_end !== 1'b0 || vif.frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL reset state x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b fc=%0d",
               vif.x, vif.y, vif.hsync, vif.vsync, vif.video_on, vif.p_tick, vif.frame_end, vif.frame_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      release_rst();
      repeat ($urandom_range(20, 400)) step();
      assert_rst();
      repeat ($urandom_range(1, 3)) step();
    end
    release_rst();
    repeat (257 * HT * VT * CD + 40) step();
    done = 1'b1;
  end
  initial begin
    fork
      wait (done);
      #5_000_000;
    join_any
    if (!done) begin
      bad++;
      $display("FAIL timeout: run did not complete, total=%0d bad=%0d", total, bad);
      $finish;
    end
  end
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        g = '{x: vif.x, y: vif.y, hs: vif.hsync, vs: vif.vsync, vo: vif.video_on,
              pt: vif.p_tick, fe: vif.frame_end, fc: vif.frame_cnt};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL raster t=%0t got x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b fc=%0d exp x=%0d y=%0d hs=%b vs=%b vo=%b pt=%b fe=%b fc=%0d",
                   $time, g.x, g.y, g.hs, g.vs, g.vo, g.pt, g.fe, g.fc,
                   e.x, e.y, e.hs, e.vs, e.vo, e.pt, e.fe, e.fc);
        end
      end else if (done) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end
endmodule
